// File: rtl/tree_path_pkg.sv
// Shared definitions for the tree path encoder/decoder pair.
// A path is a sequence of digits, one per hierarchy level (sw0 first); digit k at
// level n selects instance inst_k below the level-n node.
package tree_path_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 10;  // max hierarchy levels per path
  localparam int unsigned DEFAULT_FANOUT  = 5;   // children per node
  localparam int unsigned DEFAULT_DIGIT_W = 3;   // bits per digit, 2**DIGIT_W >= FANOUT

  typedef enum logic [0:0] {
    COLLECT,
    HOLD
  } state_e;

  typedef logic [DEFAULT_DIGIT_W-1:0]               digit_t;
  typedef logic [DEFAULT_DEPTH*DEFAULT_DIGIT_W-1:0] path_t;

endpackage

// File: rtl/tree_path_decoder.sv
// tree_path_decoder: reassembles a serialized switch-path into a packed path word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     input digit handshake
//   s_digit, s_last     digit for the current level, final-digit marker
//   m_valid/m_ready     decoded path handshake
//   m_path              digit i at [i*DIGIT_W +: DIGIT_W], sw0 at i=0
//   m_depth             number of digits stored (1..DEPTH)
//   m_error             illegal digit seen or more than DEPTH digits received
module tree_path_decoder
  import tree_path_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned FANOUT  = DEFAULT_FANOUT,
  parameter int unsigned DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DIGIT_W-1:0]         s_digit,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DEPTH*DIGIT_W-1:0]   m_path,
  output logic [$clog2(DEPTH+1)-1:0] m_depth,
  output logic                       m_error
);

  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH);

  state_e                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_count, w_count_nxt;
  logic [DEPTH*DIGIT_W-1:0] r_path,  w_path_nxt;
  logic                     r_error, w_error_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_path  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_path  <= w_path_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_path_nxt  = r_path;
    w_error_nxt = r_error;
    unique case (r_state)
      COLLECT: begin
        // s_ready is constant 1 here, so s_valid alone qualifies the accept.
        if (s_valid) begin
          if (r_count < MAX_COUNT) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (r_count == CNT_W'(i)) begin
                w_path_nxt[i*DIGIT_W +: DIGIT_W] = s_digit;
              end
            end
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            // Overflow: digit dropped, error is sticky until the path is taken.
            w_error_nxt = 1'b1;
          end
          if (32'(s_digit) >= FANOUT) begin
            w_error_nxt = 1'b1;
          end
          if (s_last) begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_state_nxt = COLLECT;
          w_count_nxt = '0;
          w_path_nxt  = '0;
          w_error_nxt = 1'b0;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Handshake flags depend on state only: no m_ready -> s_ready combinational path.
  assign s_ready = (r_state == COLLECT);
  assign m_valid = (r_state == HOLD);
  assign m_path  = r_path;
  assign m_depth = r_count;
  assign m_error = r_error;

endmodule

// File: tb/tb_tree_path_decoder.sv
module tb_tree_path_decoder;
  import tree_path_pkg::*;

  localparam int unsigned DEPTH   = DEFAULT_DEPTH;
  localparam int unsigned FANOUT  = DEFAULT_FANOUT;
  localparam int unsigned DIGIT_W = DEFAULT_DIGIT_W;

  logic                       clk;
  logic                       rst_n;
  logic                       s_valid;
  logic                       s_ready;
  logic [DIGIT_W-1:0]         s_digit;
  logic                       s_last;
  logic                       m_valid;
  logic                       m_ready;
  logic [DEPTH*DIGIT_W-1:0]   m_path;
  logic [$clog2(DEPTH+1)-1:0] m_depth;
  logic                       m_error;

  int n_checks = 0;
  int n_errors = 0;

  // Digits of the path currently being sent.
  int unsigned cur[$];

  tree_path_decoder #(
    .DEPTH  (DEPTH),
    .FANOUT (FANOUT),
    .DIGIT_W(DIGIT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_digit(s_digit),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_path (m_path),
    .m_depth(m_depth),
    .m_error(m_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a path is the first DEPTH digits, depth saturates at DEPTH, and the
  // error flag is raised by any out-of-range digit or by too many digits.
  function automatic void model_path(output path_t p, output int unsigned dep, output logic err);
    p   = '0;
    err = 1'b0;
    foreach (cur[i]) begin
      if (cur[i] >= FANOUT) err = 1'b1;
      if (i < DEPTH) p[i*DIGIT_W +: DIGIT_W] = digit_t'(cur[i]);
      else err = 1'b1;
    end
    dep = (cur.size() > DEPTH) ? DEPTH : cur.size();
  endfunction

  task automatic send_digit(input string tag, input int unsigned d, input logic last);
    @(negedge clk);
    s_valid = 1'b1;
    s_digit = DIGIT_W'(d);
    s_last  = last;
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check_eq({tag, "_no_early_valid"}, 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_path(input string tag, input int hold);
    path_t       ep;
    int unsigned ed;
    logic        ee;
    model_path(ep, ed, ee);
    for (int i = 0; i < cur.size(); i++) send_digit(tag, cur[i], i == cur.size() - 1);
    // One cycle after the last digit was accepted.
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd1);
    check_eq({tag, "_m_depth"}, 64'(m_depth), 64'(ed));
    check_eq({tag, "_m_error"}, 64'(m_error), 64'(ee));
    check_eq({tag, "_m_path"},  64'(m_path),  64'(ep));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      s_valid = 1'b1;  // must be ignored while holding
      s_digit = DIGIT_W'($urandom_range(0, 4));
      s_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
      check_eq({tag, "_hold_ready"}, 64'(s_ready), 64'd0);
      check_eq({tag, "_hold_path"},  64'(m_path),  64'(ep));
      check_eq({tag, "_hold_depth"}, 64'(m_depth), 64'(ed));
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check_eq({tag, "_ready_not_comb"}, 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check_eq({tag, "_release_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_release_ready"}, 64'(s_ready), 64'd1);
    check_eq({tag, "_release_depth"}, 64'(m_depth), 64'd0);
    check_eq({tag, "_release_path"},  64'(m_path),  64'd0);
    check_eq({tag, "_release_error"}, 64'(m_error), 64'd0);
    cur.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check_eq({tag, "_m_path"},  64'(m_path),  64'd0);
    check_eq({tag, "_m_depth"}, 64'(m_depth), 64'd0);
    check_eq({tag, "_m_error"}, 64'(m_error), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_digit = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #3;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cur = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 3};
    run_path("full", 0);

    cur = '{2, 4};
    run_path("backpressure", 5);

    cur = '{1, 5, 0};
    run_path("illegal", 1);
    cur = '{0};
    run_path("after_illegal", 0);

    cur = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_path("overflow", 0);

    cur = '{3};
    run_path("single", 2);

    // Abort a partially received path with an asynchronous reset between edges.
    send_digit("midframe", 2, 1'b0);
    send_digit("midframe", 3, 1'b0);
    send_digit("midframe", 4, 1'b0);
    send_digit("midframe", 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cur = '{0, 1};
    run_path("after_reset", 0);

    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 9) < 8) cur.push_back($urandom_range(0, FANOUT - 1));
        else cur.push_back($urandom_range(FANOUT, (1 << DIGIT_W) - 1));
      end
      run_path("random", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tree_path_decoder.md
Name: tree_path_decoder

Overview:
- Receives a serialized switch-path (one digit per hierarchy level, sw0 first) over a valid/ready stream.
- Reassembles the digits into a packed path word and presents it, with depth and error status, on a valid/ready output.
- It is the receiving end of the path encoding used by the generated rootModule hierarchy, where instance inst_k at level n corresponds to digit swn = k.
- It sits between the test-stimulus path serializer and the leaf-selection and coverage logic.

Parameters:
- DEPTH, 10, maximum number of hierarchy levels (digits) per path.
- FANOUT, 5, number of children per node; a legal digit is in 0..FANOUT-1.
- DIGIT_W, 3, bits per digit; must satisfy 2**DIGIT_W >= FANOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  input digit valid.
- s_ready  output  1  decoder can accept a digit.
- s_digit  input  DIGIT_W  path digit for the current level.
- s_last  input  1  marks the final digit of the path.
- m_valid  output  1  decoded path available.
- m_ready  input  1  consumer accepts the path.
- m_path  output  DEPTH*DIGIT_W  digit i occupies bits [i*DIGIT_W +: DIGIT_W]; sw0 is at i=0.
- m_depth  output  $clog2(DEPTH+1)  number of digits stored, 1..DEPTH.
- m_error  output  1  path contained an illegal digit or exceeded DEPTH.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = COLLECT, count = 0, path register = 0, error = 0.
  - m_valid = 0, s_ready = 1, m_path = 0, m_depth = 0, m_error = 0.
- State COLLECT:
  - s_ready = 1, m_valid = 0.
  - A digit is accepted on a cycle where s_valid && s_ready.
  - If count < DEPTH: the digit is written to slot count, then count increments.
  - If count == DEPTH: the digit is discarded, count holds, and the sticky error bit is set (overflow).
  - If the accepted digit is >= FANOUT: the sticky error bit is set and the digit is still stored when a slot is available.
  - An accepted digit with s_last = 1 moves the block to HOLD on the next edge.
- State HOLD:
  - s_ready = 0, m_valid = 1.
  - m_path, m_depth and m_error are stable and driven directly from registers.
  - On m_valid && m_ready: the next edge clears the path register, count and error, and returns to COLLECT.
- Timing:
  - Latency: m_valid rises on the cycle after the s_last digit is accepted.
  - Throughput: one path per (digits + 1) cycles when m_ready is held at 1.
  - No combinational path from m_ready to s_ready.
- m_depth equals count; a single-digit path with s_last gives m_depth = 1.
- Slots at and above count read as 0.
- s_valid is ignored in HOLD, so no digit is lost, because the upstream must hold s_valid under the handshake.
- Reset asserted mid-frame or in HOLD aborts immediately to reset values. The partial path is not emitted.
- s_digit and s_last are don't-care when s_valid = 0.

Decomposition:
- Shared package tree_path_pkg holds:
  - DEPTH, FANOUT and DIGIT_W defaults;
  - the state enum {COLLECT, HOLD};
  - a typedef for the digit;
  - a typedef for the packed path word.
- No sub-module is warranted. The decoder is a single FSM plus a datapath. The future tree_path_encoder (transmitter side) will reuse the same package.

Test Plan:
- Legal full path. Send 0,0,0,0,0,0,1,2,2,3 with s_last on the 10th digit and m_ready = 1.
  - m_valid is asserted one cycle after the last digit.
  - m_depth = 10, m_error = 0, and slot 6 = 1, slots 7 and 8 = 2, slot 9 = 3.
- Backpressure. Send 2,4 with last and hold m_ready = 0 for 5 cycles.
  - m_valid stays 1 and the outputs stay stable.
  - s_ready = 0 throughout, and a digit presented during HOLD is not consumed.
  - With m_ready = 1, s_ready returns to 1 on the next cycle.
- Illegal digit. Send 1,5,0 with last.
  - m_error = 1, m_depth = 3, slot 1 = 5.
  - The next path 0 with last gives m_error = 0.
- Overflow. Send 11 digits of 1 with last on the 11th.
  - m_depth = 10, m_error = 1, all 10 slots = 1.
- Single digit. Send 3 with s_last.
  - m_depth = 1, m_path = 3, and all other slots = 0.
- Reset mid-frame. Accept 4 digits, assert rst_n low asynchronously between edges, then release.
  - All outputs return to reset values at once, with no m_valid pulse.
  - A new path 0,1 with last decodes with m_depth = 2.
